// File: rtl/ad9226_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad9226_capture_seq
// Brief    : Arms on a CFS start pulse, waits for an immediate or threshold
//            trigger, then writes a fixed number of (optionally decimated)
//            AD9226 samples into the DCFIFO write port.
//            Optional macro AD9226_SEQ_TAG_EN adds a first-sample flag and a
//            3-bit capture sequence number to the upper FIFO word bits.
// Revision : 1.0 - initial release
// ============================================================================
module ad9226_capture_seq #(
  parameter int DW    = 12,
  parameter int CNT_W = 16,
  parameter int DEC_W = 8,
  parameter int FW    = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       trig_mode_i,
  input  logic [DW-1:0]    trig_level_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic [DEC_W-1:0] decim_i,
  input  logic [DW-1:0]    sample_i,
  input  logic             sample_vld_i,
  input  logic             fifo_full_i,
  output logic             fifo_wr_o,
  output logic [FW-1:0]    fifo_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ARM     = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [1:0]       r_mode;
  logic [DW-1:0]    r_level;
  logic [CNT_W-1:0] r_num;
  logic [DEC_W-1:0] r_decim;

  logic [CNT_W-1:0] r_cnt;
  logic [DEC_W-1:0] r_dec_cnt;
  logic [DW-1:0]    r_prev;
  logic             r_prev_vld;

  logic             r_wr;
  logic [FW-1:0]    r_data;
  logic             r_ovf;

`ifdef AD9226_SEQ_TAG_EN
  logic [2:0]       r_seq;
`endif

  logic             w_start_ok;
  logic             w_trig;
  logic             w_arm_trig;
  logic             w_cap_vld;
  logic [DEC_W-1:0] w_dec_cur;
  logic [DEC_W-1:0] w_dec_nxt;
  logic             w_keep;
  logic             w_last;
  logic [DEC_W-1:0] w_decim_lat;
  logic [FW-1:0]    w_word;

  assign w_start_ok  = start_i && !abort_i && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_decim_lat = (decim_i == '0) ? DEC_W'(1) : decim_i;

  // Threshold crossings need a previous valid sample; mode 3 behaves as immediate.
  always_comb begin
    w_trig = 1'b1;
    case (r_mode)
      2'd1:    w_trig = r_prev_vld && (r_prev < r_level) && (sample_i >= r_level);
      2'd2:    w_trig = r_prev_vld && (r_prev > r_level) && (sample_i <= r_level);
      default: w_trig = 1'b1;
    endcase
  end

  // The trigger sample itself goes through the capture path with a fresh decimation phase.
  assign w_arm_trig = (r_state == c_ARM) && sample_vld_i && w_trig;
  assign w_cap_vld  = ((r_state == c_CAPTURE) && sample_vld_i) || w_arm_trig;
  assign w_dec_cur  = (r_state == c_ARM) ? '0 : r_dec_cnt;
  assign w_dec_nxt  = (w_dec_cur == (r_decim - DEC_W'(1))) ? '0 : (w_dec_cur + DEC_W'(1));
  assign w_keep     = w_cap_vld && (w_dec_cur == '0) && (r_cnt != r_num);
  assign w_last     = w_keep && ((r_cnt + CNT_W'(1)) == r_num);

  always_comb begin
    w_word         = '0;
    w_word[DW-1:0] = sample_i;
`ifdef AD9226_SEQ_TAG_EN
    w_word[FW-1]      = (r_cnt == '0);
    w_word[FW-2:FW-4] = r_seq;
`endif
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start_i) begin
            w_state_nxt = (num_samples_i == '0) ? c_DONE : c_ARM;
          end
        end
        c_ARM: begin
          if (w_arm_trig) begin
            w_state_nxt = w_last ? c_DONE : c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          if (w_last) begin
            w_state_nxt = c_DONE;
          end
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy_o  = (r_state == c_ARM) || (r_state == c_CAPTURE);
    done_o  = (r_state == c_DONE);
    state_o = r_state;
  end

  // Configuration, trigger history, counters and the FIFO write stage
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mode     <= '0;
      r_level    <= '0;
      r_num      <= '0;
      r_decim    <= '0;
      r_cnt      <= '0;
      r_dec_cnt  <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_wr       <= 1'b0;
      r_data     <= '0;
      r_ovf      <= 1'b0;
`ifdef AD9226_SEQ_TAG_EN
      r_seq      <= '0;
`endif
    end else begin
      r_wr <= 1'b0;
      if (w_start_ok) begin
        r_mode     <= trig_mode_i;
        r_level    <= trig_level_i;
        r_num      <= num_samples_i;
        r_decim    <= w_decim_lat;
        r_ovf      <= 1'b0;
        r_cnt      <= '0;
        r_dec_cnt  <= '0;
        r_prev_vld <= 1'b0;
`ifdef AD9226_SEQ_TAG_EN
        r_seq      <= r_seq + 3'd1;
`endif
      end else if (!abort_i) begin
        if ((r_state == c_ARM) && sample_vld_i) begin
          r_prev     <= sample_i;
          r_prev_vld <= 1'b1;
        end
        if (w_cap_vld) begin
          r_dec_cnt <= w_dec_nxt;
        end
        // A dropped sample still consumes a slot so the window length is fixed.
        if (w_keep) begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (fifo_full_i) begin
            r_ovf <= 1'b1;
          end else begin
            r_wr   <= 1'b1;
            r_data <= w_word;
          end
        end
      end
    end
  end

  assign fifo_wr_o   = r_wr;
  assign fifo_data_o = r_data;
  assign ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ad9226_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9226_capture_seq
// Brief    : Self-checking bench for ad9226_capture_seq: directed scenarios
//            plus randomized captures against a behavioural capture model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9226_capture_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  trig_mode_i = '0;
  logic [11:0] trig_level_i = '0;
  logic [15:0] num_samples_i = '0;
  logic [7:0]  decim_i = '0;
  logic [11:0] sample_i = '0;
  logic        sample_vld_i = 1'b0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_o;
  logic [15:0] fifo_data_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;
  logic [1:0]  state_o;

  ad9226_capture_seq #(.DW(12), .CNT_W(16), .DEC_W(8), .FW(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .trig_mode_i(trig_mode_i), .trig_level_i(trig_level_i),
    .num_samples_i(num_samples_i), .decim_i(decim_i), .sample_i(sample_i),
    .sample_vld_i(sample_vld_i), .fifo_full_i(fifo_full_i),
    .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int          m_phase;
  int          m_mode;
  int          m_level;
  int          m_prev;
  bit          m_pv;
  int          m_num;
  int          m_decim;
  int          m_cnt;
  int          m_dcnt;
  bit          m_wr;
  logic [15:0] m_data;
  bit          m_ovf;
  int          m_seq;
  logic [15:0] mq[$];
  logic [15:0] dq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_level = 0; m_prev = 0; m_pv = 0;
    m_num = 0; m_decim = 0; m_cnt = 0; m_dcnt = 0;
    m_wr = 0; m_data = '0; m_ovf = 0; m_seq = 0;
  endtask

  task automatic model_step();
    bit trig;
    logic [15:0] w;
    m_wr = 0;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    if (abort_i) begin
      m_phase = 0;
      return;
    end
    if (start_i && (m_phase == 0 || m_phase == 3)) begin
      m_mode  = int'(trig_mode_i);
      m_level = int'(trig_level_i);
      m_num   = int'(num_samples_i);
      m_decim = (decim_i == 0) ? 1 : int'(decim_i);
      m_ovf = 0; m_cnt = 0; m_dcnt = 0; m_pv = 0;
      m_seq = (m_seq + 1) % 8;
      m_phase = (m_num == 0) ? 3 : 1;
      return;
    end
    if (!sample_vld_i) return;
    if (m_phase == 1) begin
      case (m_mode)
        1:       trig = m_pv && (m_prev < m_level) && (int'(sample_i) >= m_level);
        2:       trig = m_pv && (m_prev > m_level) && (int'(sample_i) <= m_level);
        default: trig = 1;
      endcase
      m_prev = int'(sample_i);
      m_pv = 1;
      if (!trig) return;
      m_phase = 2;
      m_dcnt = 0;
    end
    if (m_phase != 2) return;
    if (m_dcnt == 0) begin
      if (fifo_full_i) begin
        m_ovf = 1;
      end else begin
        w = {4'h0, sample_i};
`ifdef AD9226_SEQ_TAG_EN
        w[15] = (m_cnt == 0);
        w[14:12] = 3'(m_seq);
`endif
        m_wr = 1;
        m_data = w;
        mq.push_back(w);
      end
      m_cnt++;
      if (m_cnt == m_num) m_phase = 3;
    end
    m_dcnt = (m_dcnt + 1) % m_decim;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin
    chk("fifo_wr", int'(fifo_wr_o), int'(m_wr));
    chk("fifo_data", int'(fifo_data_o), int'(m_data));
    chk("busy", int'(busy_o), int'(m_phase == 1 || m_phase == 2));
    chk("done", int'(done_o), int'(m_phase == 3));
    chk("ovf", int'(ovf_o), int'(m_ovf));
    chk("state", int'(state_o), m_phase);
    if (fifo_wr_o) dq.push_back(fifo_data_o);
  end

  task automatic cyc();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic drv(input bit st, input bit ab, input bit v, input logic [11:0] s, input bit fl);
    start_i = st; abort_i = ab; sample_vld_i = v; sample_i = s; fifo_full_i = fl;
    cyc();
  endtask

  task automatic cfg(input int mode, input int lvl, input int num, input int dec);
    trig_mode_i = 2'(mode); trig_level_i = 12'(lvl);
    num_samples_i = 16'(num); decim_i = 8'(dec);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 12'h0, 0);
  endtask

  // Literal write-log checks for both model and DUT since index base mb/db
  task automatic chk_words(input string nm, input int mb, input int db, input int n,
                           input logic [15:0] e [0:7], input logic [15:0] mask);
    chk({nm, "_nmodel"}, mq.size() - mb, n);
    chk({nm, "_ndut"}, dq.size() - db, n);
    for (int i = 0; i < n; i++) begin
      if (mb + i < mq.size()) chk({nm, "_model_word"}, int'(mq[mb + i] & mask), int'(e[i]));
      if (db + i < dq.size()) chk({nm, "_dut_word"}, int'(dq[db + i] & mask), int'(e[i]));
    end
  endtask

  initial begin
    int mb, db;
    logic [15:0] e [0:7];
    model_reset();
    idle(3);
    rstn_i = 1'b1;
    idle(2);

    // Immediate capture
    cfg(0, 0, 4, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 8; i++) drv(0, 0, 1, 12'(16 + i), 0);
    chk("imm_done", int'(done_o), 1);
    chk("imm_busy", int'(busy_o), 0);
    idle(2);
    e = '{16'h010, 16'h011, 16'h012, 16'h013, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_words("imm", mb, db, 4, e, 16'h0FFF);
    drv(0, 1, 0, 12'h0, 0);

    // Rising threshold
    cfg(1, 12'h800, 2, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 6; i++) drv(0, 0, 1, 12'(12'h7FE + i), 0);
    idle(2);
    e = '{16'h800, 16'h801, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_words("rise", mb, db, 2, e, 16'h0FFF);
    drv(0, 1, 0, 12'h0, 0);

    // Decimation with gapped valid
    cfg(0, 0, 3, 3); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    for (int k = 0; k < 9; k++) begin
      drv(0, 0, 1, 12'(k), 0);
      drv(0, 0, 0, 12'hFFF, 0);
    end
    idle(2);
    e = '{16'h000, 16'h003, 16'h006, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_words("decim", mb, db, 3, e, 16'h0FFF);

    // FIFO full during the second kept sample
    cfg(0, 0, 4, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 6; i++) drv(0, 0, 1, 12'(12'h020 + i), i == 1);
    idle(2);
    chk("full_ovf", int'(ovf_o), 1);
    chk("full_done", int'(done_o), 1);
    e = '{16'h020, 16'h022, 16'h023, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_words("full", mb, db, 3, e, 16'h0FFF);
    drv(1, 0, 0, 12'h0, 0);
    chk("restart_ovf_clr", int'(ovf_o), 0);
    drv(0, 1, 0, 12'h0, 0);

    // Abort with simultaneous start after 5 writes
    cfg(0, 0, 100, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 12'(12'h040 + i), 0);
    drv(1, 1, 1, 12'h045, 0);
    chk("abort_state", int'(state_o), 0);
    chk("abort_done", int'(done_o), 0);
    for (int i = 0; i < 6; i++) drv(0, 0, 1, 12'(12'h046 + i), 0);
    e = '{16'h040, 16'h041, 16'h042, 16'h043, 16'h044, 16'h0, 16'h0, 16'h0};
    chk_words("abort", mb, db, 5, e, 16'h0FFF);

    // Zero-length capture
    cfg(0, 0, 0, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    chk("num0_state", int'(state_o), 3);
    for (int i = 0; i < 4; i++) drv(0, 0, 1, 12'(i), 0);
    chk_words("num0", mb, db, 0, e, 16'h0FFF);
    drv(0, 1, 0, 12'h0, 0);

    // Randomized captures
    for (int ep = 0; ep < 40; ep++) begin
      int lvl;
      lvl = int'($urandom_range(100, 4000));
      cfg(int'($urandom_range(0, 3)), lvl, int'($urandom_range(0, 12)), int'($urandom_range(0, 4)));
      drv(1, 0, 0, 12'h0, 0);
      for (int c = 0; c < 50; c++) begin
        logic [11:0] s;
        if ($urandom_range(0, 1) == 1) s = 12'(lvl + int'($urandom_range(0, 20)) - 10);
        else s = 12'($urandom);
        drv($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
            $urandom_range(0, 1) == 1, s, $urandom_range(0, 99) < 20);
      end
      drv(0, 1, 0, 12'h0, 0);
    end

    // Asynchronous reset mid-capture
    cfg(0, 0, 50, 1);
    drv(1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 12'(i), 0);
    rstn_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    chk("rst_state", int'(state_o), 0);
    chk("rst_wr", int'(fifo_wr_o), 0);
    cyc();
    rstn_i = 1'b1;
    idle(2);

    // Two back-to-back captures, sequence tags start from reset
    cfg(0, 0, 2, 1); mb = mq.size(); db = dq.size();
    drv(1, 0, 0, 12'h0, 0);
    drv(0, 0, 1, 12'h100, 0);
    drv(0, 0, 1, 12'h101, 0);
    idle(2);
    drv(1, 0, 0, 12'h0, 0);
    drv(0, 0, 1, 12'h200, 0);
    drv(0, 0, 1, 12'h201, 0);
    idle(2);
`ifdef AD9226_SEQ_TAG_EN
    e = '{16'h9100, 16'h1101, 16'hA200, 16'h2201, 16'h0, 16'h0, 16'h0, 16'h0};
`else
    e = '{16'h0100, 16'h0101, 16'h0200, 16'h0201, 16'h0, 16'h0, 16'h0, 16'h0};
`endif
    chk_words("tag", mb, db, 4, e, 16'hFFFF);
    drv(0, 1, 0, 12'h0, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad9226_capture_seq.md
Name: ad9226_capture_seq

Overview:
- Sequences capture of 12-bit AD9226 samples into the DCFIFO write port feeding the CFS.
- Software arms the block through CFS registers; it waits for an immediate or threshold trigger, then writes a programmed number of samples with optional decimation.
- It reports busy, done and overflow status back to the CFS register map.
- It runs in the ADC capture clock domain. Sample data is already registered upstream and arrives with a valid strobe.

Parameters:
- DW, 12, ADC sample width.
- CNT_W, 16, width of the sample-count register.
- DEC_W, 8, width of the decimation register.
- FW, 16, FIFO word width; must be ≥ DW+4.

Ports:
- clk_i  in  1  capture clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle arm pulse from CFS.
- abort_i  in  1  one-cycle abort pulse from CFS.
- trig_mode_i  in  2  0 = immediate, 1 = rising threshold, 2 = falling threshold, 3 = reserved (treated as 0).
- trig_level_i  in  DW  unsigned threshold.
- num_samples_i  in  CNT_W  samples to write per capture.
- decim_i  in  DEC_W  keep 1 of every decim_i valid samples; 0 is treated as 1.
- sample_i  in  DW  unsigned ADC code.
- sample_vld_i  in  1  sample_i is valid this cycle.
- fifo_full_i  in  1  DCFIFO write-side full.
- fifo_wr_o  out  1  FIFO write enable.
- fifo_data_o  out  FW  FIFO write data.
- busy_o  out  1  high in ARM or CAPTURE.
- done_o  out  1  high in DONE.
- ovf_o  out  1  sticky: a sample was dropped because the FIFO was full.
- state_o  out  2  0 = IDLE, 1 = ARM, 2 = CAPTURE, 3 = DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0, previous-sample register 0, prev_valid 0.
- Configuration latch:
  - On start_i in IDLE or DONE, latch trig_mode, trig_level, num_samples and decim (0 becomes 1).
  - Clear ovf_o, the sample counter, the decimation counter and prev_valid.
  - Go to ARM.
  - start_i in ARM or CAPTURE is ignored.
- num_samples latched as 0: next state is DONE directly; no writes.
- ARM state:
  - Considers only cycles with sample_vld_i = 1.
  - Mode 0: the first valid sample is the trigger.
  - Mode 1: trigger when prev_valid && prev < level && sample_i >= level.
  - Mode 2: trigger when prev_valid && prev > level && sample_i <= level.
  - On each valid sample, prev is updated to sample_i and prev_valid is set to 1.
  - A sample equal to level on the first valid cycle does not trigger (prev_valid = 0).
- Trigger sample: it is the first captured sample and is processed with CAPTURE rules in the same cycle; state moves to CAPTURE.
- Decimation:
  - The counter resets to 0 at the trigger.
  - On each valid sample in the capture path, the sample is kept when the counter == 0.
  - The counter then increments and wraps to 0 at decim−1.
- Write:
  - A kept sample is registered. One cycle later fifo_wr_o = 1 for exactly one cycle, and fifo_data_o = {4'h0, sample}, zero-extended to FW.
  - fifo_wr_o is a single-cycle pulse per kept sample; fifo_data_o holds its last value otherwise.
- FIFO full:
  - If fifo_full_i = 1 in the cycle a kept sample is registered, no write occurs and ovf_o is set (sticky).
  - The sample still counts toward num_samples, so the capture window length is fixed.
- Completion:
  - When the kept-sample count reaches num_samples, the state goes to DONE in the cycle after the last kept sample.
  - The final fifo_wr_o pulse coincides with the first DONE cycle.
- DONE state: done_o = 1 and busy_o = 0. It holds until start_i (re-arm) or abort_i (to IDLE).
- abort_i:
  - From any state, the next state is IDLE and no further writes are issued.
  - A write already registered in that cycle is suppressed.
  - ovf_o is retained; done_o = 0.
  - abort_i wins over a simultaneous start_i.
- Counters: the sample counter saturates; it never wraps past num_samples.
- Asynchronous reset mid-capture: immediate return to reset values; the FIFO contents are not this block's concern.

Optional Feature:
- Macro: AD9226_SEQ_TAG_EN.
- When defined:
  - fifo_data_o[FW-1] = 1 for the first kept sample of a capture, 0 otherwise.
  - fifo_data_o[FW-2:FW-4] = 3-bit capture sequence number; it increments on every start_i accepted, wraps 7→0, and resets to 0.
- When undefined: the upper FW−DW bits are 0 and no sequence counter is present.

Test Plan:
- Immediate capture:
  - Stimulus: mode 0, num = 4, decim = 1, samples 0x010, 0x011, … valid every cycle.
  - Required: 4 writes of 0x0010..0x0013; done_o = 1 on the cycle of the 4th write; busy_o = 0.
- Rising trigger:
  - Stimulus: mode 1, level 0x800, ramp 0x7FE, 0x7FF, 0x800, 0x801, num = 2.
  - Required: writes 0x0800, 0x0801; nothing before.
- Decimation:
  - Stimulus: mode 0, decim = 3, num = 3, samples 0..8 valid with gaps (sample_vld_i toggling).
  - Required: writes 0, 3, 6 only.
- FIFO full:
  - Stimulus: num = 4, fifo_full_i high during the 2nd kept sample.
  - Required: 3 writes, ovf_o = 1, done_o asserts after the 4th sample period; the next start_i clears ovf_o.
- Abort mid-capture:
  - Stimulus: num = 100, abort_i after 5 writes, with start_i in the same cycle.
  - Required: state IDLE next cycle, no further fifo_wr_o, done_o = 0.
- Edge cases:
  - num = 0: DONE one cycle after start with zero writes.
  - With AD9226_SEQ_TAG_EN and two captures: first words carry bit15 = 1 and sequence numbers 1 then 2.
